sr_cmd_driver: RTL and testbench
================================

Name: sr_cmd_driver

Overview:
- Upstream command stage for the gated SR latch (ports q, qbar, s, r, clock).
- Accepts set/clear requests over a valid/ready handshake and buffers them in a small FIFO.
- Converts each request into a clean, timed pulse on s or r, followed by a guard gap with both low.
- Guarantees s=r=1 never occurs and optionally checks latch output q after each command.

Parameters:
- DEPTH, 4, request FIFO depth; power of 2, >=2.
- PULSE_W, 2, cycles s or r is held high per command; >=1.
- GAP_W, 1, cycles with s=r=0 after each pulse; >=1.

Ports:
- clock  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_op  input  1  1=set (drive s), 0=clear (drive r).
- req_ready  output  1  FIFO can accept; equals (count != DEPTH).
- s  output  1  registered set drive to latch.
- r  output  1  registered reset drive to latch.
- q  input  1  latch q feedback; used only with SR_VERIFY_EN.
- busy  output  1  (state != IDLE) || (count != 0).
- done  output  1  one-cycle pulse when a command retires.
- err  output  1  one-cycle pulse, coincident with done, on q mismatch.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high (clock port named clock, reset port named reset).
- Reset edge (also mid-operation):
  - s=0, r=0, done=0, err=0, count=0, FIFO pointers=0, FSM=IDLE.
  - req_ready=1 and busy=0 from the following cycle.
  - In-flight and queued commands are discarded.
- Push: on edge when req_valid && req_ready; req_op written at the tail.
  - Full: push refused even if a pop occurs on the same edge.
- Pop: on edge when FSM=IDLE && count!=0; head op loaded into op_reg.
  - Simultaneous push and pop (not full): count unchanged, both take effect.
  - Entry pushed into an empty FIFO is visible to the FSM the next cycle, not the same edge.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE -> DRIVE on pop: s<=op_reg, r<=~op_reg (one of them), pulse counter <= PULSE_W-1.
  - DRIVE: hold s/r; when counter==0, go to GAP, s<=0, r<=0, counter <= GAP_W-1; else decrement.
  - GAP: s=r=0; when counter==0, go to IDLE with done<=1 (and err as below); else decrement.
  - IDLE: done/err cleared the next edge unless another retire occurs (impossible back-to-back).
- Timing, request accepted on edge E into an empty idle block:
  - Pop at E+1, so s/r rises at E+1 and falls at E+1+PULSE_W.
  - done is high in the cycle after edge E+1+PULSE_W+GAP_W.
- Command period: PULSE_W+GAP_W+1 cycles. Back-to-back pulses are separated by GAP_W+1 low cycles.
- Invariant: s&&r==0 every cycle. A one-hot drive is guaranteed by construction and asserted in simulation.
- Counters sized $clog2(max(PULSE_W,GAP_W))+1 bits; no wrap beyond loaded value.
- FIFO pointers wrap modulo DEPTH.

Optional Feature:
- Macro: SR_VERIFY_EN.
- Defined:
  - q sampled on the last GAP cycle.
  - err asserted with done when q != op_reg (set expects q=1, clear expects q=0).
- Not defined:
  - q is unused and err is tied to 0.
  - All timing is identical.

Test Plan:
- Reset, then one push (req_op=1) at edge 3, PULSE_W=2, GAP_W=1 -> s=1 after edges 4-5, s=0 from edge 6, done=1 in cycle after edge 7, r=0 throughout, busy=0 after done.
- Push clear with q held at 1, SR_VERIFY_EN defined -> r pulses 2 cycles, done=1 and err=1 same cycle; with q=0 -> err=0.
- req_valid held high with ops S,C,S,C,S,C on consecutive cycles -> count reaches 4, req_ready=0, 6th op accepted only after a pop; pulses appear in order S,C,S,C,S,C with 2 idle cycles between pulses.
- Assert reset during DRIVE of a set with 2 entries queued -> s=0 after that edge, count=0, done never pulses, no further pulses.
- Push set and clear on the same cycles as a pop with count=4 -> push refused, req_ready=0, count drops to 3 then recovers on next push.
- SR_VERIFY_EN undefined, q toggled randomly during commands -> err stays 0; s/r/done timing identical to the first scenario.

Source files
------------

// File: rtl/sr_cmd_driver.sv
// sr_cmd_driver: command stage in front of a gated SR latch.
// Set/clear requests arrive over valid/ready and wait in a small FIFO.
// Each request becomes a PULSE_W-cycle pulse on s or r, followed by a
// GAP_W-cycle guard with both low.
// Optional build macro SR_VERIFY_EN: sample latch q on the last guard cycle
// and flag err with done when q does not match the command.
module sr_cmd_driver #(
   parameter int DEPTH   = 4,
   parameter int PULSE_W = 2,
   parameter int GAP_W   = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     req_valid,
   input  logic                     req_op,
   output logic                     req_ready,
   output logic                     s,
   output logic                     r,
   input  logic                     q,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW   = $clog2(DEPTH);
   localparam int MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int CW   = $clog2(MAXW) + 1;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      GAP
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            op_q;

   logic            mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;

   logic            push;
   logic            pop;
   logic            head_op;
   logic            mismatch;

   // A full FIFO refuses pushes even when a pop happens on the same edge.
   assign req_ready = (count_q != (AW+1)'(DEPTH));
   assign push      = req_valid && req_ready;
   assign pop       = (state_q == IDLE) && (count_q != '0);
   assign head_op   = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign busy      = (state_q != IDLE) || (count_q != '0);

   // Next-state for FIFO pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO control registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage; contents are only read while count is non-zero.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= req_op;
   end

`ifdef SR_VERIFY_EN
   assign mismatch = (q != op_q);
`else
   logic unused_sig;
   assign mismatch   = 1'b0;
   assign unused_sig = q ^ op_q;
`endif

   // Pulse sequencer: IDLE -> DRIVE (s or r high) -> GAP (both low) -> IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         s       <= 1'b0;
         r       <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  op_q    <= head_op;
                  s       <= head_op;
                  r       <= ~head_op;
                  cnt_q   <= CW'(PULSE_W - 1);
                  state_q <= DRIVE;
               end
            end
            DRIVE: begin
               if (cnt_q == '0) begin
                  s       <= 1'b0;
                  r       <= 1'b0;
                  cnt_q   <= CW'(GAP_W - 1);
                  state_q <= GAP;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            GAP: begin
               if (cnt_q == '0) begin
                  done    <= 1'b1;
                  err     <= mismatch;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: begin
               s       <= 1'b0;
               r       <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // The latch must never see both drives high.
   a_one_hot_drive: assert property (@(posedge clock) !(s && r));

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Testbench for sr_cmd_driver: directed scenarios followed by random traffic,
// all checked against a schedule-based reference model.
module tb_sr_cmd_driver;

   localparam int DEPTH = 4;
   localparam int PW    = 2;
   localparam int GW    = 1;
   localparam int CNTW  = $clog2(DEPTH) + 1;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            req_valid = 1'b0;
   logic            req_op = 1'b0;
   logic            req_ready;
   logic            s, r;
   logic            q = 1'b0;
   logic            busy, done, err;
   logic [CNTW-1:0] count;

   sr_cmd_driver #(
      .DEPTH   (DEPTH),
      .PULSE_W (PW),
      .GAP_W   (GW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_ready (req_ready),
      .s         (s),
      .r         (r),
      .q         (q),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .count     (count)
   );

   always #5 clock = ~clock;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   bit          armed    = 0;

   // Reference model: a queue of pending ops plus the schedule of the
   // command currently being executed (pop edge and retire edge).
   int  t       = 0;
   bit  mq[$];
   bit  act     = 0;
   bit  aop     = 0;
   int  p_start = 0;
   int  act_end = 0;
   bit  e_s = 0, e_r = 0, e_done = 0, e_err = 0, e_busy = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, t, got, exp);
      end
   endtask

   task automatic compare_all();
      check("count",     32'(count),     32'(mq.size()));
      check("req_ready", 32'(req_ready), 32'(mq.size() != DEPTH));
      check("busy",      32'(busy),      32'(e_busy));
      check("s",         32'(s),         32'(e_s));
      check("r",         32'(r),         32'(e_r));
      check("done",      32'(done),      32'(e_done));
      check("err",       32'(err),       32'(e_err));
      check("s_and_r",   32'(s && r),    32'(0));
   endtask

   task automatic model_step();
      bit push, pop, idle;
      t++;
      if (reset) begin
         mq.delete();
         act = 0; e_s = 0; e_r = 0; e_done = 0; e_err = 0; e_busy = 0;
         return;
      end
      push   = req_valid && (mq.size() != DEPTH);
      idle   = !act || (t > act_end);
      pop    = idle && (mq.size() != 0);
      e_done = act && (t == act_end);
      e_err  = 0;
`ifdef SR_VERIFY_EN
      e_err  = e_done && (q != aop);
`endif
      if (pop) begin
         aop     = mq.pop_front();
         p_start = t;
         act_end = t + PW + GW;
         act     = 1;
      end
      if (push) mq.push_back(req_op);
      e_s    = act &&  aop && (t >= p_start) && (t < p_start + PW);
      e_r    = act && !aop && (t >= p_start) && (t < p_start + PW);
      e_busy = (act && (t < act_end)) || (mq.size() != 0);
   endtask

   task automatic cycle(input logic rst, input logic rv, input logic op, input logic qv);
      @(negedge clock);
      if (armed) compare_all();
      reset     = rst;
      req_valid = rv;
      req_op    = op;
      q         = qv;
      @(posedge clock);
      model_step();
      if (rst) armed = 1;
   endtask

   task automatic idle_cycles(input int n, input logic qv);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, qv);
   endtask

   initial begin
      bit burst_ops [6] = '{1, 0, 1, 0, 1, 0};
      int k;
      int guard;

      // Reset, then a single set command into an empty, idle block.
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(0, 1, 1, 0);
      idle_cycles(8, 0);

      // Clear with q held high, then clear with q low.
      cycle(0, 1, 0, 1);
      idle_cycles(6, 1);
      cycle(0, 1, 0, 0);
      idle_cycles(6, 0);

      // Valid held high with S,C,S,C,S,C; an op advances only when accepted.
      k = 0;
      guard = 0;
      while (k < 6 && guard < 40) begin
         bit rdy;
         rdy = (mq.size() != DEPTH);
         cycle(0, 1, burst_ops[k], 0);
         if (rdy) k++;
         guard++;
      end
      check("burst_accepted", 32'(k), 32'(6));
      idle_cycles(30, 0);

      // Reset while a set is driving with more entries queued.
      cycle(0, 1, 1, 0);
      cycle(0, 1, 1, 0);
      cycle(0, 1, 0, 0);
      guard = 0;
      while (!e_s && guard < 10) begin
         cycle(0, 0, 0, 0);
         guard++;
      end
      check("drive_reached", 32'(e_s), 32'(1));
      cycle(1, 0, 0, 0);
      idle_cycles(20, 0);

      // Random traffic with occasional resets and a toggling q.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      idle_cycles(20, 0);

      @(negedge clock);
      compare_all();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
